matrix_mem_sequencer: RTL and testbench
=======================================

Name: matrix_mem_sequencer

Overview:
- Moves one 4x4 signed 32-bit matrix between the matrix math unit and the row-organised RAM: four rows of four 32-bit columns.
- A single requester issues a block LOAD (RAM -> MatrixOut) or STORE (MatrixIn -> RAM) with a base address.
- The block sequences the four row accesses on the RAM's Enable/ReadWrite/AddressSelect/column ports and signals completion with Done.
- Sits between the CPU control path and the RAM instance; it is the RAM's only master.

Parameters:
- ADDR_W, 32, width of RAM AddressSelect.
- ADDR_MAX, 255, highest legal RAM row address.
- READ_LATENCY, 1, cycles from a read Enable cycle to valid RAM OutColumn data (range 1..3).

Ports:
- Clock  in  1  system clock, rising edge.
- ResetN  in  1  asynchronous active-low reset.
- Start  in  1  request strobe, sampled only in IDLE.
- Op  in  1  0 = LOAD (read), 1 = STORE (write); same polarity as RAM ReadWrite.
- BaseAddress  in  ADDR_W  row address of matrix row 0; row r is at BaseAddress+r.
- MatrixIn  in  512  store data, row r column c at bits [(r*4+c)*32 +: 32].
- MatrixOut  out  512  load result, same packing.
- Busy  out  1  high from the cycle after an accepted Start until Done.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  one-cycle pulse on a rejected request.
- MemEnable  out  1  to RAM Enable.
- MemReadWrite  out  1  to RAM ReadWrite.
- MemAddress  out  ADDR_W  to RAM AddressSelect.
- MemWrColumn1..4  out  32 each  to RAM InColumn1..4.
- MemRdColumn1..4  in  32 each  from RAM OutColumn1..4.

Behaviour:
- Clock/reset: one clock. Reset is asynchronous and active-low.
- Reset values: all outputs 0; FSM IDLE; row counter 0; latched Op/BaseAddress/MatrixIn 0.
- Reset mid-operation: MemEnable drops immediately (asynchronously). There is no partial Done and no Error.
- FSM states: IDLE, CHECK, ISSUE, WAIT, DONE.
- IDLE: when Start=1 at an edge, latch Op, BaseAddress and MatrixIn, then go to CHECK. Start is ignored in every other state.
- CHECK (1 cycle): if BaseAddress > ADDR_MAX-3, pulse Error in this cycle, make no RAM access and return to IDLE. Otherwise set Busy and go to ISSUE with row=0.
- ISSUE (1 cycle per row):
  - MemEnable=1, MemReadWrite=latched Op, MemAddress=BaseAddress+row.
  - For STORE, MemWrColumn1..4 = latched row data.
  - STORE: if row=3 go to DONE, else row++ and stay in ISSUE. The four writes are back-to-back.
  - LOAD: go to WAIT.
- WAIT (LOAD only, READ_LATENCY cycles): MemEnable=0. On the edge ending the last WAIT cycle, capture MemRdColumn1..4 into MatrixOut row `row`. Then, if row=3 go to DONE, else row++ and go to ISSUE.
- DONE (1 cycle): Done=1, Busy=0, then IDLE.
- Latency from the Start edge (READ_LATENCY=1): STORE writes in cycles 2..5 and Done in cycle 6. LOAD enables in cycles 2,4,6,8 and Done in cycle 10. General LOAD Done cycle = 2 + 4*(1+READ_LATENCY).
- Outside ISSUE: MemEnable=0 and MemReadWrite=0. MemAddress and MemWr* hold their last values.
- MatrixOut updates row by row during a LOAD and otherwise holds until the next LOAD; it is unchanged by a STORE or an Error.
- A later change of MatrixIn or BaseAddress after acceptance has no effect.
- Address arithmetic is unsigned, ADDR_W bits. No wrap occurs, because CHECK rejects a request that would wrap.

Decomposition:
- Shared package holds:
  - state encodings: IDLE=0, CHECK=1, ISSUE=2, WAIT=3, DONE=4;
  - OP_LOAD=0 and OP_STORE=1;
  - ROWS=4, COLS=4 and COL_W=32.
- One sub-module is natural: matrix_row_buffer, a 4x128-bit register file with a row-indexed write port and a flat 512-bit read. It is used for the latched MatrixIn and for MatrixOut.

Test Plan:
- STORE at base 0, MatrixIn row0={-4,2,-4,7}, other rows {r,r,r,r}:
  - RAM rows 0..3 written in 4 consecutive Enable cycles with ReadWrite=1;
  - Done exactly 6 cycles after Start.
- LOAD at base 0 after that store:
  - MatrixOut row0={-4,2,-4,7}, rows 1..3 {1,..},{2,..},{3,..};
  - 4 single-cycle Enable pulses with ReadWrite=0;
  - Done at cycle 10.
- STORE at base 4 with row0={3,83,-88,92}, then LOAD base 4:
  - data is returned intact;
  - rows 0..3 at base 0 are unchanged, checked by re-loading base 0.
- BaseAddress=253 with ADDR_MAX=255 -> Error pulse in cycle 1, no MemEnable, Busy stays 0, MatrixOut unchanged.
- Start pulsed again while Busy, and MatrixIn changed mid-STORE -> the second Start is ignored and the RAM receives the originally latched data.
- ResetN low during a LOAD WAIT:
  - MemEnable, Busy and Done go 0 immediately;
  - after release the FSM is IDLE and a new LOAD completes normally.

Source files
------------

// File: rtl/matrix_mem_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// matrix_mem_sequencer_pkg
// Shared definitions for the matrix memory sequencer: matrix geometry,
// operation encodings, FSM state encoding and a row-slice helper.
// No ports (package).
// ---------------------------------------------------------------------------
package matrix_mem_sequencer_pkg;

  // Matrix geometry: four rows of four signed 32-bit columns
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int COL_W = 32;
  localparam int ROW_W = COLS * COL_W;
  localparam int MAT_W = ROWS * ROW_W;

  // Operation encoding, same polarity as the RAM ReadWrite pin
  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef logic [1:0] row_idx_t;

  localparam row_idx_t ROW_LAST = 2'(ROWS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Extract one 128-bit row from a flat 512-bit matrix
  function automatic logic [ROW_W-1:0] rowSlice(input logic [MAT_W-1:0] mat,
                                                input row_idx_t row);
    return mat[row*ROW_W +: ROW_W];
  endfunction

endpackage

// File: rtl/matrix_mem_sequencer_row_buffer.sv
// ---------------------------------------------------------------------------
// matrix_row_buffer
// 4 x 128-bit register file holding one matrix. It can be loaded whole in a
// single cycle (used to latch the store operand) or one row at a time (used
// to assemble the load result). The whole matrix is always readable flat.
//
// Ports:
//   i_Clock    - system clock, rising edge
//   i_ResetN   - asynchronous active-low reset, clears every row
//   i_LoadAll  - load all four rows from i_AllData (has priority)
//   i_AllData  - flat 512-bit matrix to load
//   i_RowWrEn  - write i_RowData into row i_RowSel
//   i_RowSel   - row index for the single-row write
//   i_RowData  - 128-bit row data
//   o_Data     - flat 512-bit view of the stored matrix
// ---------------------------------------------------------------------------
module matrix_row_buffer
  import matrix_mem_sequencer_pkg::*;
(
  input  logic             i_Clock,
  input  logic             i_ResetN,
  input  logic             i_LoadAll,
  input  logic [MAT_W-1:0] i_AllData,
  input  logic             i_RowWrEn,
  input  row_idx_t         i_RowSel,
  input  logic [ROW_W-1:0] i_RowData,
  output logic [MAT_W-1:0] o_Data
);

  logic [ROW_W-1:0] r_Rows [ROWS];

  // Whole-matrix load wins over a single-row write; the sequencer never
  // asks for both on the same instance.
  always_ff @(posedge i_Clock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      for (int r = 0; r < ROWS; r++) begin
        r_Rows[r] <= '0;
      end
    end else if (i_LoadAll) begin
      for (int r = 0; r < ROWS; r++) begin
        r_Rows[r] <= i_AllData[r*ROW_W +: ROW_W];
      end
    end else if (i_RowWrEn) begin
      r_Rows[i_RowSel] <= i_RowData;
    end
  end

  // Flatten the rows back into the packed matrix layout
  always_comb begin
    o_Data = '0;
    for (int r = 0; r < ROWS; r++) begin
      o_Data[r*ROW_W +: ROW_W] = r_Rows[r];
    end
  end

endmodule

// File: rtl/matrix_mem_sequencer.sv
// ---------------------------------------------------------------------------
// matrix_mem_sequencer
// Moves one 4x4 signed 32-bit matrix between the matrix math unit and the
// row-organised RAM. A LOAD reads four consecutive RAM rows into
// o_MatrixOut; a STORE writes the latched i_MatrixIn into four consecutive
// rows. This block is the only master of the RAM.
//
// Ports:
//   i_Clock, i_ResetN         - clock (rising edge), async active-low reset
//   i_Start                   - request strobe, only looked at in IDLE
//   i_Op                      - 0 = LOAD, 1 = STORE
//   i_BaseAddress             - RAM row of matrix row 0
//   i_MatrixIn                - store operand, row r col c at (r*4+c)*32
//   o_MatrixOut               - load result, same packing
//   o_Busy                    - transfer in progress
//   o_Done                    - one-cycle completion pulse
//   o_Error                   - one-cycle pulse for a rejected base address
//   o_MemEnable/ReadWrite/Address, o_MemWrColumn1..4 - RAM request side
//   i_MemRdColumn1..4         - RAM read data
// ---------------------------------------------------------------------------
module matrix_mem_sequencer
  import matrix_mem_sequencer_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int ADDR_MAX     = 255,
  parameter int READ_LATENCY = 1
)(
  input  logic              i_Clock,
  input  logic              i_ResetN,
  input  logic              i_Start,
  input  logic              i_Op,
  input  logic [ADDR_W-1:0] i_BaseAddress,
  input  logic [MAT_W-1:0]  i_MatrixIn,
  output logic [MAT_W-1:0]  o_MatrixOut,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Error,
  output logic              o_MemEnable,
  output logic              o_MemReadWrite,
  output logic [ADDR_W-1:0] o_MemAddress,
  output logic [COL_W-1:0]  o_MemWrColumn1,
  output logic [COL_W-1:0]  o_MemWrColumn2,
  output logic [COL_W-1:0]  o_MemWrColumn3,
  output logic [COL_W-1:0]  o_MemWrColumn4,
  input  logic [COL_W-1:0]  i_MemRdColumn1,
  input  logic [COL_W-1:0]  i_MemRdColumn2,
  input  logic [COL_W-1:0]  i_MemRdColumn3,
  input  logic [COL_W-1:0]  i_MemRdColumn4
);

  // Highest base address whose four rows still fit below ADDR_MAX
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(ADDR_MAX - (ROWS - 1));
  localparam logic [1:0]        LAST_WAIT = 2'(READ_LATENCY - 1);

  state_t            r_State;
  state_t            w_NextState;
  row_idx_t          r_Row;
  logic [1:0]        r_WaitCnt;
  logic              r_Op;
  logic [ADDR_W-1:0] r_Base;
  logic [ADDR_W-1:0] r_LastAddr;
  logic [ROW_W-1:0]  r_LastWr;

  logic [MAT_W-1:0]  w_InMatrix;
  logic [ROW_W-1:0]  w_RowData;
  logic [ROW_W-1:0]  w_RdRow;
  logic [ROW_W-1:0]  w_MemWr;
  logic [ADDR_W-1:0] w_RowAddr;
  logic              w_Accept;
  logic              w_BaseBad;
  logic              w_LastWait;
  logic              w_Capture;
  logic              w_Busy;
  logic              w_Done;
  logic              w_Error;
  logic              w_MemEnable;
  logic              w_MemReadWrite;

  assign w_Accept   = (r_State == ST_IDLE) && i_Start;
  assign w_BaseBad  = r_Base > LAST_BASE;
  assign w_LastWait = r_WaitCnt == LAST_WAIT;
  assign w_Capture  = (r_State == ST_WAIT) && w_LastWait;
  assign w_RowData  = rowSlice(w_InMatrix, r_Row);
  assign w_RowAddr  = r_Base + ADDR_W'(r_Row);
  assign w_RdRow    = {i_MemRdColumn4, i_MemRdColumn3, i_MemRdColumn2, i_MemRdColumn1};

  // Store operand snapshot, taken when the request is accepted so later
  // changes of i_MatrixIn cannot leak into the transfer.
  matrix_row_buffer u_InBuf (
    .i_Clock   (i_Clock),
    .i_ResetN  (i_ResetN),
    .i_LoadAll (w_Accept),
    .i_AllData (i_MatrixIn),
    .i_RowWrEn (1'b0),
    .i_RowSel  (2'b00),
    .i_RowData ({ROW_W{1'b0}}),
    .o_Data    (w_InMatrix)
  );

  // Load result, filled one row per completed read
  matrix_row_buffer u_OutBuf (
    .i_Clock   (i_Clock),
    .i_ResetN  (i_ResetN),
    .i_LoadAll (1'b0),
    .i_AllData ({MAT_W{1'b0}}),
    .i_RowWrEn (w_Capture),
    .i_RowSel  (r_Row),
    .i_RowData (w_RdRow),
    .o_Data    (o_MatrixOut)
  );

  // State register
  always_ff @(posedge i_Clock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      r_State <= ST_IDLE;
    end else begin
      r_State <= w_NextState;
    end
  end

  // Next state and the per-state control outputs. Everything here is
  // decoded from the state register, so reset clears MemEnable and Busy
  // without waiting for a clock edge.
  always_comb begin
    w_NextState    = r_State;
    w_Busy         = 1'b0;
    w_Done         = 1'b0;
    w_Error        = 1'b0;
    w_MemEnable    = 1'b0;
    w_MemReadWrite = 1'b0;
    case (r_State)
      ST_IDLE: begin
        if (i_Start) begin
          w_NextState = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_BaseBad) begin
          w_Error     = 1'b1;
          w_NextState = ST_IDLE;
        end else begin
          w_NextState = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_Busy         = 1'b1;
        w_MemEnable    = 1'b1;
        w_MemReadWrite = r_Op;
        if (r_Op == OP_STORE) begin
          if (r_Row == ROW_LAST) begin
            w_NextState = ST_DONE;
          end
        end else begin
          w_NextState = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_Busy = 1'b1;
        if (w_LastWait) begin
          w_NextState = (r_Row == ROW_LAST) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: begin
        w_Done      = 1'b1;
        w_NextState = ST_IDLE;
      end
      default: begin
        w_NextState = ST_IDLE;
      end
    endcase
  end

  // Request latch, row/wait counters and the "last driven" RAM address and
  // write data, which the RAM pins hold whenever no access is issued.
  always_ff @(posedge i_Clock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      r_Op       <= OP_LOAD;
      r_Base     <= '0;
      r_Row      <= '0;
      r_WaitCnt  <= '0;
      r_LastAddr <= '0;
      r_LastWr   <= '0;
    end else begin
      if (w_Accept) begin
        r_Op   <= i_Op;
        r_Base <= i_BaseAddress;
      end
      if (r_State == ST_CHECK) begin
        r_Row     <= '0;
        r_WaitCnt <= '0;
      end
      if (r_State == ST_ISSUE) begin
        r_LastAddr <= w_RowAddr;
        if (r_Op == OP_STORE) begin
          r_LastWr <= w_RowData;
          if (r_Row != ROW_LAST) begin
            r_Row <= r_Row + 2'd1;
          end
        end else begin
          r_WaitCnt <= '0;
        end
      end
      if (r_State == ST_WAIT) begin
        if (w_LastWait) begin
          if (r_Row != ROW_LAST) begin
            r_Row <= r_Row + 2'd1;
          end
        end else begin
          r_WaitCnt <= r_WaitCnt + 2'd1;
        end
      end
    end
  end

  // RAM pins: live values during ISSUE, held values otherwise
  assign w_MemWr = ((r_State == ST_ISSUE) && (r_Op == OP_STORE)) ? w_RowData : r_LastWr;

  assign o_MemAddress   = (r_State == ST_ISSUE) ? w_RowAddr : r_LastAddr;
  assign o_MemWrColumn1 = w_MemWr[0*COL_W +: COL_W];
  assign o_MemWrColumn2 = w_MemWr[1*COL_W +: COL_W];
  assign o_MemWrColumn3 = w_MemWr[2*COL_W +: COL_W];
  assign o_MemWrColumn4 = w_MemWr[3*COL_W +: COL_W];
  assign o_MemEnable    = w_MemEnable;
  assign o_MemReadWrite = w_MemReadWrite;
  assign o_Busy         = w_Busy;
  assign o_Done         = w_Done;
  assign o_Error        = w_Error;

endmodule

// File: tb/tb_matrix_mem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_matrix_mem_sequencer
// Self-checking bench for matrix_mem_sequencer with a behavioural RAM
// (one-cycle read latency) and a scoreboard of expected RAM accesses and
// expected load results.
// ---------------------------------------------------------------------------
module tb_matrix_mem_sequencer;
  import matrix_mem_sequencer_pkg::*;

  localparam int ADDR_W       = 32;
  localparam int ADDR_MAX     = 255;
  localparam int READ_LATENCY = 1;
  localparam int STORE_DONE   = 2 + ROWS;
  localparam int LOAD_DONE    = 2 + ROWS * (1 + READ_LATENCY);

  typedef struct {
    logic             rw;
    logic [31:0]      addr;
    logic [ROW_W-1:0] data;
    int               cyc;
  } acc_t;

  logic              clock = 1'b0;
  logic              resetN = 1'b1;
  logic              start = 1'b0;
  logic              op = 1'b0;
  logic [31:0]       baseAddress = '0;
  logic [MAT_W-1:0]  matrixIn = '0;
  logic [MAT_W-1:0]  matrixOut;
  logic              busy, done, error;
  logic              memEnable, memReadWrite;
  logic [31:0]       memAddress;
  logic [31:0]       memWrColumn1, memWrColumn2, memWrColumn3, memWrColumn4;
  logic [31:0]       memRdColumn1, memRdColumn2, memRdColumn3, memRdColumn4;
  logic [ROW_W-1:0]  ramRdData = '0;
  logic [ROW_W-1:0]  memWrData;

  logic [ROW_W-1:0]  ram [256];
  logic [ROW_W-1:0]  modelRam [256];
  logic [MAT_W-1:0]  expMatOut = '0;
  acc_t              accQ [$];
  logic [MAT_W-1:0]  loadQ [$];
  acc_t              monE;

  int cyc = 0;
  int startCyc = 0;
  int checks = 0;
  int errors = 0;
  bit monEn = 1'b0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  matrix_mem_sequencer #(
    .ADDR_W       (ADDR_W),
    .ADDR_MAX     (ADDR_MAX),
    .READ_LATENCY (READ_LATENCY)
  ) dut (
    .i_Clock        (clock),
    .i_ResetN       (resetN),
    .i_Start        (start),
    .i_Op           (op),
    .i_BaseAddress  (baseAddress),
    .i_MatrixIn     (matrixIn),
    .o_MatrixOut    (matrixOut),
    .o_Busy         (busy),
    .o_Done         (done),
    .o_Error        (error),
    .o_MemEnable    (memEnable),
    .o_MemReadWrite (memReadWrite),
    .o_MemAddress   (memAddress),
    .o_MemWrColumn1 (memWrColumn1),
    .o_MemWrColumn2 (memWrColumn2),
    .o_MemWrColumn3 (memWrColumn3),
    .o_MemWrColumn4 (memWrColumn4),
    .i_MemRdColumn1 (memRdColumn1),
    .i_MemRdColumn2 (memRdColumn2),
    .i_MemRdColumn3 (memRdColumn3),
    .i_MemRdColumn4 (memRdColumn4)
  );

  assign memWrData    = {memWrColumn4, memWrColumn3, memWrColumn2, memWrColumn1};
  assign memRdColumn1 = ramRdData[31:0];
  assign memRdColumn2 = ramRdData[63:32];
  assign memRdColumn3 = ramRdData[95:64];
  assign memRdColumn4 = ramRdData[127:96];

  // Behavioural RAM: synchronous write, read data valid one cycle later
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]      = '0;
      modelRam[i] = '0;
    end
  end

  always @(posedge clock) begin
    if (memEnable === 1'b1) begin
      if (memReadWrite === 1'b1) ram[memAddress[7:0]] <= memWrData;
      else                       ramRdData <= ram[memAddress[7:0]];
    end
  end

  // Scoreboard: every enabled RAM cycle must match the next expected access
  always @(negedge clock) begin
    if (monEn) begin
      checks++;
      if (memEnable === 1'b1) begin
        if (accQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_access: cyc=%0d addr=%0d rw=%0b, required no access",
                   cyc - startCyc, memAddress, memReadWrite);
        end else begin
          monE = accQ.pop_front();
          if (memReadWrite !== monE.rw || memAddress !== monE.addr || cyc !== monE.cyc ||
              (monE.rw && memWrData !== monE.data)) begin
            errors++;
            $display("[TB] FAIL access: got rw=%0b addr=%0d cyc=%0d data=%h, required rw=%0b addr=%0d cyc=%0d data=%h",
                     memReadWrite, memAddress, cyc - startCyc, memWrData,
                     monE.rw, monE.addr, monE.cyc - startCyc, monE.data);
          end
        end
      end else if (memReadWrite !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_readwrite: got %0b, required 0", memReadWrite);
      end
    end
  end

  function automatic logic [ROW_W-1:0] mkRow(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  // Drive one request and push the accesses/results it should produce.
  // Returns at the negedge of cycle 1 (the CHECK cycle).
  task automatic applyStimulus(input logic opIn, input logic [31:0] base, input logic [MAT_W-1:0] mat);
    acc_t e;
    logic [MAT_W-1:0] expMat;
    int idx;
    @(negedge clock);
    op          = opIn;
    baseAddress = base;
    matrixIn    = mat;
    start       = 1'b1;
    startCyc    = cyc;
    expMat      = '0;
    if (base <= 32'(ADDR_MAX - 3)) begin
      for (int r = 0; r < ROWS; r++) begin
        idx    = int'(base) + r;
        e.rw   = opIn;
        e.addr = base + 32'(r);
        if (opIn == OP_STORE) begin
          e.data        = mat[r*ROW_W +: ROW_W];
          e.cyc         = startCyc + 2 + r;
          modelRam[idx] = e.data;
        end else begin
          e.data = '0;
          e.cyc  = startCyc + 2 + r * (1 + READ_LATENCY);
          expMat[r*ROW_W +: ROW_W] = modelRam[idx];
        end
        accQ.push_back(e);
      end
      if (opIn == OP_LOAD) loadQ.push_back(expMat);
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic waitDone(output int doneCyc, output int busyCnt);
    doneCyc = -1;
    busyCnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (busy === 1'b1) busyCnt++;
      if (done === 1'b1) begin
        doneCyc = cyc - startCyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetN = 1'b1;
    #2 resetN = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_status: got busy=%0b done=%0b error=%0b, required 0 0 0", busy, done, error);
    end
    checks++;
    if (memEnable !== 1'b0 || memReadWrite !== 1'b0 || memAddress !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_mem: got en=%0b rw=%0b addr=%0d, required 0 0 0", memEnable, memReadWrite, memAddress);
    end
    checks++;
    if (memWrData !== '0) begin
      errors++;
      $display("[TB] FAIL reset_wrdata: got %h, required 0", memWrData);
    end
    checks++;
    if (matrixOut !== '0) begin
      errors++;
      $display("[TB] FAIL reset_matrixout: got %h, required 0", matrixOut);
    end
    resetN = 1'b1;
    monEn  = 1'b1;
  endtask

  task automatic test_store(input logic [31:0] base, input logic [MAT_W-1:0] mat, input string label);
    int doneCyc, busyCnt;
    applyStimulus(OP_STORE, base, mat);
    waitDone(doneCyc, busyCnt);
    checks++;
    if (doneCyc !== STORE_DONE) begin
      errors++;
      $display("[TB] FAIL %s_done_cycle: got %0d, required %0d", label, doneCyc, STORE_DONE);
    end
    checks++;
    if (busyCnt !== ROWS) begin
      errors++;
      $display("[TB] FAIL %s_busy_cycles: got %0d, required %0d", label, busyCnt, ROWS);
    end
    checks++;
    if (accQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL %s_missing_access: got %0d pending, required 0", label, accQ.size());
      accQ.delete();
    end
    checks++;
    if (matrixOut !== expMatOut) begin
      errors++;
      $display("[TB] FAIL %s_matrixout_held: got %h, required %h", label, matrixOut, expMatOut);
    end
  endtask

  task automatic test_load(input logic [31:0] base, input string label);
    int doneCyc, busyCnt;
    logic [MAT_W-1:0] expMat;
    applyStimulus(OP_LOAD, base, {MAT_W{1'b1}});
    waitDone(doneCyc, busyCnt);
    checks++;
    if (doneCyc !== LOAD_DONE) begin
      errors++;
      $display("[TB] FAIL %s_done_cycle: got %0d, required %0d", label, doneCyc, LOAD_DONE);
    end
    checks++;
    if (busyCnt !== ROWS * (1 + READ_LATENCY)) begin
      errors++;
      $display("[TB] FAIL %s_busy_cycles: got %0d, required %0d", label, busyCnt, ROWS * (1 + READ_LATENCY));
    end
    checks++;
    if (accQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL %s_missing_access: got %0d pending, required 0", label, accQ.size());
      accQ.delete();
    end
    expMat = loadQ.pop_front();
    checks++;
    if (matrixOut !== expMat) begin
      errors++;
      $display("[TB] FAIL %s_data: got %h, required %h", label, matrixOut, expMat);
    end
    expMatOut = expMat;
  endtask

  task automatic test_error();
    int errCnt = 0, busyCnt = 0, doneCnt = 0;
    logic [MAT_W-1:0] mat;
    for (int r = 0; r < ROWS; r++) mat[r*ROW_W +: ROW_W] = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(OP_STORE, 32'd253, mat);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL error_pulse: got error=%0b busy=%0b, required 1 0", error, busy);
    end
    for (int k = 2; k <= 9; k++) begin
      @(negedge clock);
      if (error === 1'b1) errCnt++;
      if (busy === 1'b1) busyCnt++;
      if (done === 1'b1) doneCnt++;
    end
    checks++;
    if (errCnt !== 0 || busyCnt !== 0 || doneCnt !== 0) begin
      errors++;
      $display("[TB] FAIL error_after: got error=%0d busy=%0d done=%0d cycles, required 0 0 0", errCnt, busyCnt, doneCnt);
    end
    checks++;
    if (matrixOut !== expMatOut) begin
      errors++;
      $display("[TB] FAIL error_matrixout_held: got %h, required %h", matrixOut, expMatOut);
    end
  endtask

  task automatic test_back_to_back();
    int doneCyc = -1, busyCnt = 0, doneCnt = 0;
    logic [MAT_W-1:0] mat;
    for (int r = 0; r < ROWS; r++) mat[r*ROW_W +: ROW_W] = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(OP_STORE, 32'd8, mat);
    for (int k = 2; k <= 14; k++) begin
      @(negedge clock);
      if (k == 3) begin
        start       = 1'b1;
        op          = OP_LOAD;
        baseAddress = 32'd100;
        matrixIn    = ~mat;
      end
      if (k == 7) start = 1'b0;
      if (busy === 1'b1) busyCnt++;
      if (done === 1'b1) begin
        doneCnt++;
        doneCyc = cyc - startCyc;
      end
    end
    checks++;
    if (doneCyc !== STORE_DONE || doneCnt !== 1) begin
      errors++;
      $display("[TB] FAIL b2b_done: got cycle=%0d count=%0d, required %0d 1", doneCyc, doneCnt, STORE_DONE);
    end
    checks++;
    if (busyCnt !== ROWS) begin
      errors++;
      $display("[TB] FAIL b2b_busy_cycles: got %0d, required %0d", busyCnt, ROWS);
    end
    checks++;
    if (accQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_missing_access: got %0d pending, required 0", accQ.size());
      accQ.delete();
    end
  endtask

  task automatic test_reset_mid_load();
    applyStimulus(OP_LOAD, 32'd0, '0);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midload_busy_before: got %0b, required 1", busy);
    end
    #1 resetN = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || memEnable !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midload_async: got busy=%0b en=%0b done=%0b error=%0b, required 0 0 0 0",
               busy, memEnable, done, error);
    end
    checks++;
    if (matrixOut !== '0) begin
      errors++;
      $display("[TB] FAIL midload_matrixout: got %h, required 0", matrixOut);
    end
    accQ.delete();
    loadQ.delete();
    expMatOut = '0;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midload_held: got busy=%0b done=%0b, required 0 0", busy, done);
    end
    resetN = 1'b1;
    test_load(32'd0, "reload_after_reset");
  endtask

  initial begin
    logic [MAT_W-1:0] m0, m4;
    $display("[TB] starting matrix_mem_sequencer bench");
    test_reset();

    m0 = '0;
    m0[0*ROW_W +: ROW_W] = mkRow(-4, 2, -4, 7);
    for (int r = 1; r < ROWS; r++) m0[r*ROW_W +: ROW_W] = mkRow(r, r, r, r);
    test_store(32'd0, m0, "store_base0");
    test_load(32'd0, "load_base0");

    m4 = '0;
    m4[0*ROW_W +: ROW_W] = mkRow(3, 83, -88, 92);
    for (int r = 1; r < ROWS; r++) m4[r*ROW_W +: ROW_W] = {$urandom, $urandom, $urandom, $urandom};
    test_store(32'd4, m4, "store_base4");
    test_load(32'd4, "load_base4");
    test_load(32'd0, "reload_base0");

    test_error();
    test_load(32'd252, "load_base252");

    test_back_to_back();
    test_load(32'd8, "load_base8");

    test_reset_mid_load();

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
